// File: rtl/coverage.sv
// ----------------------------------------------------------------------------
// coverage : functional-coverage collector for a single-retire trace port.
// Optional trap-cross bitmaps are enabled by defining COVERAGE_TRAP_CROSS_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module coverage #(
    parameter int ILEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [ILEN-1:0]  insn,
    input  logic             trap,
    input  logic             clear,
    output logic [CNT_W-1:0] insn_count,
    output logic [CNT_W-1:0] trap_count,
    output logic [31:0]      opcode_hits,
    output logic [2:0]       cmp_hits,
    output logic [5:0]       bins_hit,
    output logic             full_cov,
    output logic             sample_pulse
`ifdef COVERAGE_TRAP_CROSS_EN
    ,
    output logic [31:0]      trap_hits,
    output logic [2:0]       trap_cmp_hits,
    output logic [5:0]       trap_bins_hit
`endif
);

    localparam logic [5:0] c_ALL_BINS = 6'd35;

    logic [CNT_W-1:0] r_insn_count;
    logic [CNT_W-1:0] r_trap_count;
    logic [31:0]      r_opcode_hits;
    logic [2:0]       r_cmp_hits;
    logic             r_sample_pulse;

    logic             w_is32;
    logic [31:0]      w_op_onehot;
    logic [2:0]       w_cmp_onehot;
    logic             w_hit;
    logic             w_trap_hit;
    logic [5:0]       w_bins;
    logic             w_unused_insn;

    // Only the low seven bits carry decode information.
    assign w_unused_insn = ^insn[ILEN-1:7];

    assign w_is32       = (insn[1:0] == 2'b11);
    assign w_op_onehot  = w_is32 ? (32'd1 << insn[6:2]) : 32'd0;
    assign w_cmp_onehot = w_is32 ? 3'd0 : (3'd1 << insn[1:0]);
    assign w_hit        = valid & ~trap;
    assign w_trap_hit   = valid & trap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_insn_count   <= '0;
            r_trap_count   <= '0;
            r_opcode_hits  <= '0;
            r_cmp_hits     <= '0;
            r_sample_pulse <= 1'b0;
        end else if (clear) begin
            r_insn_count   <= '0;
            r_trap_count   <= '0;
            r_opcode_hits  <= '0;
            r_cmp_hits     <= '0;
            r_sample_pulse <= 1'b0;
        end else begin
            r_sample_pulse <= valid;
            if (w_hit) begin
                // Saturate instead of wrapping so long runs stay meaningful.
                if (r_insn_count != {CNT_W{1'b1}})
                    r_insn_count <= r_insn_count + 1'b1;
                r_opcode_hits <= r_opcode_hits | w_op_onehot;
                r_cmp_hits    <= r_cmp_hits | w_cmp_onehot;
            end
            if (w_trap_hit && (r_trap_count != {CNT_W{1'b1}}))
                r_trap_count <= r_trap_count + 1'b1;
        end
    end

    always_comb begin
        w_bins = 6'd0;
        for (int k = 0; k < 32; k++)
            w_bins = w_bins + {5'd0, r_opcode_hits[k]};
        for (int q = 0; q < 3; q++)
            w_bins = w_bins + {5'd0, r_cmp_hits[q]};
    end

    assign insn_count   = r_insn_count;
    assign trap_count   = r_trap_count;
    assign opcode_hits  = r_opcode_hits;
    assign cmp_hits     = r_cmp_hits;
    assign bins_hit     = w_bins;
    assign full_cov     = (w_bins == c_ALL_BINS);
    assign sample_pulse = r_sample_pulse;

`ifdef COVERAGE_TRAP_CROSS_EN
    logic [31:0] r_trap_hits;
    logic [2:0]  r_trap_cmp_hits;
    logic [5:0]  w_trap_bins;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trap_hits     <= '0;
            r_trap_cmp_hits <= '0;
        end else if (clear) begin
            r_trap_hits     <= '0;
            r_trap_cmp_hits <= '0;
        end else if (w_trap_hit) begin
            r_trap_hits     <= r_trap_hits | w_op_onehot;
            r_trap_cmp_hits <= r_trap_cmp_hits | w_cmp_onehot;
        end
    end

    always_comb begin
        w_trap_bins = 6'd0;
        for (int k = 0; k < 32; k++)
            w_trap_bins = w_trap_bins + {5'd0, r_trap_hits[k]};
        for (int q = 0; q < 3; q++)
            w_trap_bins = w_trap_bins + {5'd0, r_trap_cmp_hits[q]};
    end

    assign trap_hits     = r_trap_hits;
    assign trap_cmp_hits = r_trap_cmp_hits;
    assign trap_bins_hit = w_trap_bins;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coverage.sv
// ----------------------------------------------------------------------------
// tb_coverage : scoreboard bench for coverage (CNT_W = 8 to reach saturation).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_coverage;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic [31:0] insn;
    logic        trap;
    logic        clear;
    logic [7:0]  insn_count;
    logic [7:0]  trap_count;
    logic [31:0] opcode_hits;
    logic [2:0]  cmp_hits;
    logic [5:0]  bins_hit;
    logic        full_cov;
    logic        sample_pulse;
`ifdef COVERAGE_TRAP_CROSS_EN
    logic [31:0] trap_hits;
    logic [2:0]  trap_cmp_hits;
    logic [5:0]  trap_bins_hit;
`endif

    coverage #(.ILEN(32), .CNT_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid        (valid),
        .insn         (insn),
        .trap         (trap),
        .clear        (clear),
        .insn_count   (insn_count),
        .trap_count   (trap_count),
        .opcode_hits  (opcode_hits),
        .cmp_hits     (cmp_hits),
        .bins_hit     (bins_hit),
        .full_cov     (full_cov),
        .sample_pulse (sample_pulse)
`ifdef COVERAGE_TRAP_CROSS_EN
        ,
        .trap_hits     (trap_hits),
        .trap_cmp_hits (trap_cmp_hits),
        .trap_bins_hit (trap_bins_hit)
`endif
    );

    typedef struct {
        logic [7:0]  ic;
        logic [7:0]  tc;
        logic [31:0] op;
        logic [2:0]  cm;
        logic [5:0]  bh;
        logic        fc;
        logic [31:0] top;
        logic [2:0]  tcm;
    } exp_t;

    exp_t q_exp[$];

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_ic, m_tc;
    logic [31:0] m_op, m_top;
    logic [2:0]  m_cm, m_tcm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ic = '0; m_tc = '0; m_op = '0; m_cm = '0; m_top = '0; m_tcm = '0;
    endtask

    task automatic issue(input logic [31:0] i, input logic t);
        exp_t e;
        @(posedge clk); #1;
        valid = 1'b1; insn = i; trap = t; clear = 1'b0;
        if (t) begin
            if (m_tc != 8'hFF) m_tc = m_tc + 8'd1;
            if (i[1:0] == 2'b11) m_top[i[6:2]] = 1'b1; else m_tcm[i[1:0]] = 1'b1;
        end else begin
            if (m_ic != 8'hFF) m_ic = m_ic + 8'd1;
            if (i[1:0] == 2'b11) m_op[i[6:2]] = 1'b1; else m_cm[i[1:0]] = 1'b1;
        end
        e.ic = m_ic; e.tc = m_tc; e.op = m_op; e.cm = m_cm;
        e.bh = 6'($countones({m_op, m_cm}));
        e.fc = (e.bh == 6'd35);
        e.top = m_top; e.tcm = m_tcm;
        q_exp.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid = 1'b0; trap = 1'b0; insn = 32'hxxxx_xxxx; clear = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".insn_count"}, 64'(insn_count), 64'd0);
        chk({tag, ".trap_count"}, 64'(trap_count), 64'd0);
        chk({tag, ".opcode_hits"}, 64'(opcode_hits), 64'd0);
        chk({tag, ".cmp_hits"}, 64'(cmp_hits), 64'd0);
        chk({tag, ".bins_hit"}, 64'(bins_hit), 64'd0);
        chk({tag, ".full_cov"}, 64'(full_cov), 64'd0);
        chk({tag, ".sample_pulse"}, 64'(sample_pulse), 64'd0);
`ifdef COVERAGE_TRAP_CROSS_EN
        chk({tag, ".trap_hits"}, 64'(trap_hits), 64'd0);
        chk({tag, ".trap_cmp_hits"}, 64'(trap_cmp_hits), 64'd0);
        chk({tag, ".trap_bins_hit"}, 64'(trap_bins_hit), 64'd0);
`endif
    endtask

    // Monitor: every sample_pulse presents the state produced by one retirement.
    always @(negedge clk) begin
        if (reset_n && sample_pulse) begin
            if (q_exp.size() == 0) begin
                chk("mon.unexpected_pulse", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("mon.insn_count", 64'(insn_count), 64'(e.ic));
                chk("mon.trap_count", 64'(trap_count), 64'(e.tc));
                chk("mon.opcode_hits", 64'(opcode_hits), 64'(e.op));
                chk("mon.cmp_hits", 64'(cmp_hits), 64'(e.cm));
                chk("mon.bins_hit", 64'(bins_hit), 64'(e.bh));
                chk("mon.full_cov", 64'(full_cov), 64'(e.fc));
`ifdef COVERAGE_TRAP_CROSS_EN
                chk("mon.trap_hits", 64'(trap_hits), 64'(e.top));
                chk("mon.trap_cmp_hits", 64'(trap_cmp_hits), 64'(e.tcm));
                chk("mon.trap_bins_hit", 64'(trap_bins_hit),
                    64'($countones({e.top, e.tcm})));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        reset_n = 1'b0; valid = 1'b0; trap = 1'b0; clear = 1'b0; insn = 32'h13;

        // Reset held while valid toggles.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1; valid = ~valid;
        end
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1; reset_n = 1'b1; valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_zero("idle");

        // Single ADDI sample and one-cycle pulse.
        issue(32'h0000_0013, 1'b0);
        idle();
        @(negedge clk);
        chk("addi.insn_count", 64'(insn_count), 64'd1);
        chk("addi.opcode_hits", 64'(opcode_hits), 64'h10);
        chk("addi.bins_hit", 64'(bins_hit), 64'd1);
        chk("addi.pulse_hi", 64'(sample_pulse), 64'd1);
        @(negedge clk);
        chk("addi.pulse_lo", 64'(sample_pulse), 64'd0);

        // Trapping ECALL then compressed c.li.
        issue(32'h0000_0073, 1'b1);
        issue(32'h0000_4501, 1'b0);
        idle();
        @(negedge clk);
        chk("mix.trap_count", 64'(trap_count), 64'd1);
        chk("mix.opcode_hits", 64'(opcode_hits), 64'h10);
        chk("mix.cmp_hits", 64'(cmp_hits), 64'b010);
        chk("mix.insn_count", 64'(insn_count), 64'd2);

        // Every opcode and quadrant, back to back.
        for (int k = 0; k < 32; k++) issue({25'd0, 5'(k), 2'b11}, 1'b0);
        for (int qd = 0; qd < 3; qd++) issue({30'd0, 2'(qd)}, 1'b0);
        idle();
        @(negedge clk);
        chk("full.bins_hit", 64'(bins_hit), 64'd35);
        chk("full.full_cov", 64'(full_cov), 64'd1);
        chk("full.insn_count", 64'(insn_count), 64'd37);
        issue(32'h0000_0013, 1'b0);
        idle();
        @(negedge clk);
        chk("repeat.bins_hit", 64'(bins_hit), 64'd35);

        // Clear wins over a simultaneous valid sample.
        @(posedge clk); #1;
        valid = 1'b1; trap = 1'b0; insn = 32'h0000_0033; clear = 1'b1;
        model_reset();
        @(posedge clk); #1;
        valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk_zero("clear");

        // Saturation at 8 bits.
        for (int n = 0; n < 300; n++) issue(32'h0000_0013, 1'b0);
        idle();
        @(negedge clk);
        chk("sat.insn_count", 64'(insn_count), 64'hFF);
        @(negedge clk);
        chk("sb.drained", 64'(q_exp.size()), 64'd0);

        // Asynchronous reset in the middle of activity.
        issue(32'h0000_0073, 1'b1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        q_exp.delete();
        model_reset();
        #1;
        chk_zero("async_rst");
        valid = 1'b0;
        @(posedge clk); #1; reset_n = 1'b1;

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
